// File: rtl/seq_divider_param.sv
// seq_divider_param: sequential restoring divider, control unit and datapath in one block.
// Operands are captured when a request is accepted. The divider then runs one shift/subtract
// pair per quotient bit on the magnitudes. A final fix-up step applies signs and flags.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset; aborts any operation in progress
//   go           start request (level); acted on only in IDLE and DONE
//   signed_mode  1 = two's-complement divide (ignored when SIGNED_EN = 0)
//   dividend     X operand, WIDTH bits
//   divisor      Y operand, WIDTH bits
//   quotient     registered quotient
//   remainder    registered remainder
//   busy         1 in LOAD, SHIFT, SUB, FIX
//   done         1 only in DONE
//   div_by_zero  divisor was zero (valid with done)
//   ovf          signed quotient not representable (valid with done)
//   cs           current state code (IDLE=0 LOAD=1 SHIFT=2 SUB=3 FIX=4 DONE=5)
module seq_divider_param #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             ovf,
  output logic [2:0]       cs
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StSub   = 3'd3,
    StFix   = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   busy_d, done_d;

  // Captured operands
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;

  // Working registers: R is one bit wider so the post-shift partial remainder never truncates
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
  logic             neg_q, r_ge, ovf_fix;

  always_comb begin
    mag_a   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    neg_q   = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_ge    = (r_q >= {1'b0, y_q});
    q_fix   = neg_q ? -x_q : x_q;
    // Truncating division: remainder follows the dividend's sign
    r_fix   = (sgn_q && a_q[WIDTH-1]) ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
    // Only +2^(WIDTH-1) is unrepresentable; the quotient then wraps to MIN unchanged
    ovf_fix = sgn_q && !neg_q && (x_q == {1'b1, {(WIDTH-1){1'b0}}});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = go ? StLoad : StIdle;
      StLoad:  state_d = (mag_b == '0) ? StDone : StShift;
      StShift: state_d = StSub;
      StSub:   state_d = (cnt_q == CW'(1)) ? StFix : StShift;
      StFix:   state_d = StDone;
      StDone:  state_d = go ? StDone : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from next state, registered below so busy/done are flop outputs
  always_comb begin
    busy_d = (state_d == StLoad) || (state_d == StShift) ||
             (state_d == StSub) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  assign cs = state_q;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      r_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (go) begin
            a_q   <= dividend;
            b_q   <= divisor;
            sgn_q <= SIGNED_EN && signed_mode;
          end
        end
        StLoad: begin
          x_q         <= mag_a;
          y_q         <= mag_b;
          r_q         <= '0;
          cnt_q       <= CW'(WIDTH);
          ovf         <= 1'b0;
          div_by_zero <= (mag_b == '0);
          if (mag_b == '0) begin
            quotient  <= '1;
            remainder <= a_q;
          end
        end
        StShift: begin
          {r_q, x_q} <= {r_q[WIDTH-1:0], x_q, 1'b0};
        end
        StSub: begin
          if (r_ge) begin
            r_q    <= r_q - {1'b0, y_q};
            x_q[0] <= 1'b1;
          end
          cnt_q <= cnt_q - CW'(1);
        end
        StFix: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
